// File: rtl/noise_var_stream.sv
// Streaming population variance/mean over power-of-two windows of signed samples.
// Exact integer datapath: var = ((sumsq << k) - sum^2) >> 2k, mean = sum >>> k.
module noise_var_stream #(
    parameter int unsigned DATA_W   = 13,
    parameter int unsigned MAX_LOG2 = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [$clog2(MAX_LOG2+1)-1:0]        win_log2,
    input  logic                                 auto_restart,
    input  logic                                 abort,
    input  logic                                 in_valid,
    input  logic signed [DATA_W-1:0]             in_data,
    output logic                                 in_ready,
    output logic                                 out_valid,
    output logic [2*DATA_W-1:0]                  out_var,
    output logic signed [DATA_W-1:0]             out_mean,
    input  logic                                 out_ready,
    output logic                                 busy
);
    localparam int unsigned KW    = $clog2(MAX_LOG2 + 1);
    localparam int unsigned SUM_W = DATA_W + MAX_LOG2;
    localparam int unsigned SQ_W  = 2 * DATA_W + MAX_LOG2;
    localparam int unsigned P_W   = 2 * DATA_W;
    localparam int unsigned D_W   = 2 * SUM_W;
    localparam int unsigned CNT_W = MAX_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CALC, S_OUT} state_e;

    state_e                    state_q, state_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic [SQ_W-1:0]           sumsq_q, sumsq_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [KW-1:0]             k_q, k_d;
    logic                      auto_q, auto_d;
    logic [P_W-1:0]            var_q, var_d;
    logic signed [DATA_W-1:0]  mean_q, mean_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;

    logic [KW-1:0]             k_clamp_c;
    logic signed [P_W-1:0]     din_x_c, din_sq_c;
    logic signed [D_W-1:0]     sum_x_c, sum_sq_c;
    logic [D_W-1:0]            d_c;
    logic [CNT_W-1:0]          win_cnt_c;

    // Exact datapath terms; the subtraction is non-negative by Cauchy-Schwarz
    always_comb begin
        k_clamp_c = (win_log2 > KW'(MAX_LOG2)) ? KW'(MAX_LOG2) : win_log2;
        din_x_c   = P_W'(in_data);
        din_sq_c  = din_x_c * din_x_c;
        sum_x_c   = D_W'(sum_q);
        sum_sq_c  = sum_x_c * sum_x_c;
        d_c       = (D_W'(sumsq_q) << k_q) - D_W'($unsigned(sum_sq_c));
        win_cnt_c = CNT_W'(1) << k_q;
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        count_d = count_q;
        k_d     = k_q;
        auto_d  = auto_q;
        var_d   = var_q;
        mean_d  = mean_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = k_clamp_c;
                    auto_d  = auto_restart;
                    sum_d   = '0;
                    sumsq_d = '0;
                    count_d = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    sum_d   = sum_q + SUM_W'(in_data);
                    sumsq_d = sumsq_q + SQ_W'($unsigned(din_sq_c));
                    count_d = count_q + CNT_W'(1);
                    if (count_q + CNT_W'(1) == win_cnt_c) state_d = S_CALC;
                end
            end
            S_CALC: begin
                var_d   = P_W'(d_c >> {k_q, 1'b0});
                mean_d  = DATA_W'(sum_q >>> k_q);
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (auto_q) begin
                        sum_d   = '0;
                        sumsq_d = '0;
                        count_d = '0;
                        state_d = S_ACCUM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Cancel wins over start and out_ready; last result stays on out_var/out_mean
        if (abort) begin
            state_d = S_IDLE;
            sum_d   = '0;
            sumsq_d = '0;
            count_d = '0;
        end

        in_ready_d  = (state_d == S_ACCUM);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            sumsq_q     <= '0;
            count_q     <= '0;
            k_q         <= '0;
            auto_q      <= 1'b0;
            var_q       <= '0;
            mean_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            sumsq_q     <= sumsq_d;
            count_q     <= count_d;
            k_q         <= k_d;
            auto_q      <= auto_d;
            var_q       <= var_d;
            mean_q      <= mean_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_var   = var_q;
    assign out_mean  = mean_q;
    assign busy      = busy_q;
endmodule
